// File: rtl/img_pkg.sv
// Shared types and defaults for the image line feeder.
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    typedef logic [7:0] pixel_t;

    localparam int DEF_WIDTH  = 512;
    localparam int DEF_HEIGHT = 512;

endpackage

// File: rtl/img_skid_fifo.sv
// Two-entry pixel FIFO decoupling memory read latency from downstream backpressure.
module img_skid_fifo
    import img_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  pixel_t     push_data,
    output logic       out_valid,
    output pixel_t     out_data,
    input  logic       out_ready,
    output logic [1:0] count
);

    pixel_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/img_line_feeder.sv
// Streams an image from pixel memory line by line, pacing lines on processor interrupts.
// Define IMG_LINE_FEEDER_PAD_EN to append PAD_LINES zero lines after the image.
module img_line_feeder
    import img_pkg::*;
#(
    parameter int IMG_WIDTH     = DEF_WIDTH,
    parameter int IMG_HEIGHT    = DEF_HEIGHT,
    parameter int PREFILL_LINES = 4,
    parameter int PAD_LINES     = 2,
    parameter int ADDR_W        = 18
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_start,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic              o_data_valid,
    output logic [7:0]        o_data,
    input  logic              i_data_ready,
    input  logic              i_intr,
    output logic              o_busy,
    output logic              o_done
);

`ifdef IMG_LINE_FEEDER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int TOTAL_LINES = IMG_HEIGHT + (PAD_EN ? PAD_LINES : 0);
    localparam int LW          = (TOTAL_LINES > 1) ? $clog2(TOTAL_LINES) : 1;
    localparam int CW          = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int PREFILL_LEN = PREFILL_LINES * IMG_WIDTH;
    localparam int SEG_MAX     = (PREFILL_LEN > IMG_WIDTH) ? PREFILL_LEN : IMG_WIDTH;
    localparam int SW          = $clog2(SEG_MAX + 1);

    state_t            state, state_nx;
    logic [LW-1:0]     line;
    logic [CW-1:0]     col;
    logic [ADDR_W-1:0] addr;
    logic [SW-1:0]     seg_issued, seg_xfer, seg_len;
    logic [1:0]        pend, fifo_cnt;
    logic [2:0]        occ;
    logic              last_issued, intr_q, issue_d, pad_d;
    logic              intr_edge, take_intr, xfer, seg_end, issue, pad;
    logic              line_end, last_pix, credit, active;
    pixel_t            push_data;

    assign line_end  = (col == CW'(IMG_WIDTH - 1));
    assign last_pix  = line_end && (line == LW'(TOTAL_LINES - 1));
    assign pad       = PAD_EN && ({1'b0, line} >= (LW+1)'(IMG_HEIGHT));
    assign intr_edge = i_intr && !intr_q;
    assign take_intr = (state == ST_WAIT) && (pend != 2'd0);
    assign xfer      = o_data_valid && i_data_ready;
    assign seg_len   = (state == ST_PREFILL) ? SW'(PREFILL_LEN) : SW'(IMG_WIDTH);
    assign seg_end   = xfer && (seg_xfer == seg_len - 1'b1);
    assign active    = (state == ST_PREFILL) || (state == ST_SEND);

    // A read may only launch if its data is guaranteed a FIFO slot when it lands.
    assign occ    = {1'b0, fifo_cnt} + {2'b00, issue_d};
    assign credit = (occ < 3'd2) || ((occ == 3'd2) && xfer);
    assign issue  = active && !last_issued && (seg_issued != seg_len) && credit;

    assign o_rd_en   = issue && !pad;
    assign o_rd_addr = addr;
    assign o_busy    = (state != ST_IDLE);
    assign o_done    = (state == ST_DONE);
    assign push_data = pad_d ? '0 : i_rd_data;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:             if (i_start) state_nx = ST_PREFILL;
            ST_PREFILL, ST_SEND: if (seg_end) state_nx = last_issued ? ST_DONE : ST_WAIT;
            ST_WAIT:             if (take_intr) state_nx = ST_SEND;
            ST_DONE:             state_nx = ST_IDLE;
            default:             state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state       <= ST_IDLE;
            line        <= '0;
            col         <= '0;
            addr        <= '0;
            seg_issued  <= '0;
            seg_xfer    <= '0;
            pend        <= 2'd0;
            last_issued <= 1'b0;
            intr_q      <= 1'b0;
            issue_d     <= 1'b0;
            pad_d       <= 1'b0;
        end else begin
            state   <= state_nx;
            intr_q  <= i_intr;
            issue_d <= issue;
            pad_d   <= pad;

            if (intr_edge && !take_intr && pend != 2'd3)
                pend <= pend + 2'd1;
            else if (take_intr && !intr_edge)
                pend <= pend - 2'd1;

            if (state != state_nx) begin
                seg_issued <= '0;
                seg_xfer   <= '0;
            end else begin
                if (issue) seg_issued <= seg_issued + 1'b1;
                if (xfer)  seg_xfer   <= seg_xfer + 1'b1;
            end

            if (state == ST_IDLE && i_start) begin
                line        <= '0;
                col         <= '0;
                addr        <= '0;
                last_issued <= 1'b0;
            end else if (issue) begin
                if (last_pix) begin
                    line        <= '0;
                    col         <= '0;
                    addr        <= '0;
                    last_issued <= 1'b1;
                end else begin
                    if (!pad) addr <= addr + 1'b1;
                    if (line_end) begin
                        col  <= '0;
                        line <= line + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

    img_skid_fifo u_fifo (
        .clk       (axi_clk),
        .reset     (axi_reset),
        .push      (issue_d),
        .push_data (push_data),
        .out_valid (o_data_valid),
        .out_data  (o_data),
        .out_ready (i_data_ready),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_img_line_feeder.sv
// Scoreboard bench for img_line_feeder on a small 4x8 image; honours IMG_LINE_FEEDER_PAD_EN.
module tb_img_line_feeder;

    localparam int W  = 4;
    localparam int H  = 8;
    localparam int PL = 4;
    localparam int PD = 2;
    localparam int AW = 18;
`ifdef IMG_LINE_FEEDER_PAD_EN
    localparam int TOT = H + PD;
`else
    localparam int TOT = H;
`endif

    logic          axi_clk = 1'b0;
    logic          axi_reset = 1'b1;
    logic          i_start = 1'b0;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [7:0]    i_rd_data;
    logic          o_data_valid;
    logic [7:0]    o_data;
    logic          i_data_ready = 1'b1;
    logic          i_intr = 1'b0;
    logic          o_busy;
    logic          o_done;

    int         checks = 0;
    int         fails = 0;
    logic [7:0] exp_q [$];
    int         exp_addr = 0;
    int         frame_xfer = 0;
    int         done_cnt = 0;
    int         intr_req = 0;
    bit         auto_intr = 1'b0;
    bit         rand_rdy = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 axi_clk = ~axi_clk;

    img_line_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PREFILL_LINES(PL), .PAD_LINES(PD), .ADDR_W(AW)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset    (axi_reset),
        .i_start      (i_start),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .i_data_ready (i_data_ready),
        .i_intr       (i_intr),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    function automatic logic [7:0] mem_f(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Memory model: one-cycle read latency, junk when not read so stray pushes show up.
    always @(posedge axi_clk)
        i_rd_data <= o_rd_en ? mem_f(int'(o_rd_addr)) : 8'hA5;

    always @(posedge axi_clk) begin
        #1;
        i_data_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(posedge axi_clk) begin
        #2;
        if (i_intr)
            i_intr = 1'b0;
        else if (intr_req > 0) begin
            i_intr = 1'b1;
            intr_req--;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge axi_clk) begin
        if (prev_stall) begin
            chk("stall_valid_hold", o_data_valid, 1);
            chk("stall_data_hold", o_data, prev_data);
        end
        prev_stall = o_data_valid && !i_data_ready && !axi_reset;
        prev_data  = o_data;
        if (o_rd_en) begin
            chk("rd_addr", o_rd_addr, exp_addr);
            exp_addr++;
        end
        if (o_data_valid && i_data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pixel: got %0d with no pixel expected", o_data);
            end else begin
                chk("pixel", o_data, exp_q.pop_front());
            end
            frame_xfer++;
            if (auto_intr && frame_xfer % W == 0 && frame_xfer >= PL * W && frame_xfer < TOT * W)
                intr_req++;
        end
        if (o_done) begin
            done_cnt++;
            chk("done_after_last_pixel", exp_q.size(), 0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic prep_frame();
        exp_q.delete();
        for (int l = 0; l < TOT; l++)
            for (int c = 0; c < W; c++)
                exp_q.push_back((l < H) ? mem_f(l * W + c) : 8'h00);
        exp_addr   = 0;
        frame_xfer = 0;
        done_cnt   = 0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_rd_en"}, o_rd_en, 0);
        chk({name, "_rd_addr"}, o_rd_addr, 0);
        chk({name, "_valid"}, o_data_valid, 0);
        chk({name, "_data"}, o_data, 0);
        chk({name, "_busy"}, o_busy, 0);
        chk({name, "_done"}, o_done, 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_finished_in_budget"}, o_busy, 0);
    endtask

    task automatic end_checks(input string name);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_read_count"}, exp_addr, H * W);
        chk({name, "_pixels_left"}, exp_q.size(), 0);
        chk({name, "_pixel_count"}, frame_xfer, TOT * W);
    endtask

    task automatic run_full(input string name, input bit check_tput);
        int n = 0;
        int m = 0;
        prep_frame();
        pulse_start();
        chk({name, "_busy_after_start"}, o_busy, 1);
        while (!o_data_valid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_first_valid_latency_ge2"}, (n + 1) >= 2 && n < 50, 1);
        if (check_tput) begin
            while (frame_xfer < PL * W && m < 100) begin
                tick();
                m++;
            end
            chk({name, "_prefill_one_per_cycle"}, m, PL * W);
        end
        wait_idle(name, 3000);
        end_checks(name);
    endtask

    initial begin
        int n;
        tick(3);
        check_outputs_zero("reset");
        axi_reset = 1'b0;
        tick();

        // Full frame, ready always high, interrupt whenever a line is needed.
        auto_intr = 1'b1;
        rand_rdy  = 1'b0;
        run_full("full_ready", 1'b1);
        tick(3);

        // Same frame under random backpressure.
        rand_rdy = 1'b1;
        run_full("rand_ready", 1'b0);
        rand_rdy = 1'b0;
        tick(3);

        // Four interrupt edges during prefill: only three are banked.
        auto_intr = 1'b0;
        prep_frame();
        pulse_start();
        intr_req = 4;
        tick(100);
        chk("sat_lines_sent", frame_xfer, (PL + 3) * W);
        chk("sat_stalled_busy", o_busy, 1);
        intr_req = TOT - PL - 3;
        wait_idle("sat", 3000);
        end_checks("sat");
        tick(3);

        // Start request mid-frame is ignored.
        auto_intr = 1'b1;
        prep_frame();
        pulse_start();
        n = 0;
        while (frame_xfer < PL * W + 2 && n < 500) begin
            tick();
            n++;
        end
        pulse_start();
        wait_idle("start_ignored", 3000);
        end_checks("start_ignored");
        tick(3);

        // Reset in the middle of line 5, then a clean replay from address 0.
        prep_frame();
        pulse_start();
        n = 0;
        while (frame_xfer < 5 * W + 1 && n < 500) begin
            tick();
            n++;
        end
        chk("abort_reached_line5", frame_xfer, 5 * W + 1);
        axi_reset = 1'b1;
        intr_req  = 0;
        tick();
        check_outputs_zero("abort");
        chk("abort_no_done", done_cnt, 0);
        axi_reset = 1'b0;
        tick(2);
        run_full("replay", 1'b0);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
